// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int cs_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_param_clk_gen.sv
// SCLK divider: half-period tick plus leading/trailing edge strobes during XFER.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic xfer,
  output logic tick,
  output logic lead,
  output logic trail
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             phase;

  assign tick  = en && (cnt == CNT_W'(CLK_DIV - 1));
  assign lead  = tick && xfer && !phase;
  assign trail = tick && xfer && phase;

  // Counter is held at zero outside an active transfer so SETUP always starts on a fresh phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      if (!en || tick) cnt <= '0;
      else             cnt <= cnt + 1'b1;
      if (!xfer)       phase <= 1'b0;
      else if (tick)   phase <= ~phase;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: all four modes, selectable bit order, NUM_CS selects.
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int CLK_DIV = 2,
  parameter  int NUM_CS  = 1,
  localparam int CS_W    = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int BIT_W = $clog2(DATA_W) + 1;

  state_t            state_q, state_d;
  logic              cpol_q, cpha_q, lsb_q;
  logic              samp;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              tick, lead, trail;
  logic              accept, last_bit;

  function automatic logic out_bit(input logic [DATA_W-1:0] s, input logic lsb);
    return lsb ? s[0] : s[DATA_W-1];
  endfunction

  // Received bits enter on the side opposite the outgoing bit.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s,
                                                 input logic lsb, input logic b);
    return lsb ? {b, s[DATA_W-1:1]} : {s[DATA_W-2:0], b};
  endfunction

  assign accept   = (state_q == IDLE) && start && (int'(cs_sel) < NUM_CS);
  assign last_bit = (bit_cnt == BIT_W'(DATA_W - 1));
  assign sreg_nxt = shift_in(sreg, lsb_q, cpha_q ? miso : samp);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != IDLE),
    .xfer (state_q == XFER),
    .tick (tick),
    .lead (lead),
    .trail(trail)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept)            state_d = SETUP;
      SETUP: if (tick)              state_d = XFER;
      XFER:  if (trail && last_bit) state_d = HOLD;
      HOLD:  if (tick)              state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= '1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      samp    <= 1'b0;
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sclk <= cpol;
          mosi <= 1'b0;
          cs_n <= '1;
          busy <= 1'b0;
          if (accept) begin
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            lsb_q   <= lsb_first;
            sreg    <= tx_data;
            bit_cnt <= '0;
            busy    <= 1'b1;
            cs_n    <= ~(NUM_CS'(1) << cs_sel);
            mosi    <= cpha ? 1'b0 : out_bit(tx_data, lsb_first);
          end
        end
        XFER: begin
          if (tick) sclk <= ~sclk;
          if (lead) begin
            if (cpha_q) mosi <= out_bit(sreg, lsb_q);
            else        samp <= miso;
          end
          if (trail) begin
            sreg    <= sreg_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (!cpha_q && !last_bit) mosi <= out_bit(sreg_nxt, lsb_q);
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n    <= '1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= sreg;
            mosi    <= 1'b0;
            sclk    <= cpol_q;
            bit_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Table-driven bench with a bit/word scoreboard and an independent SPI slave model.
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int DW    = 8;
  localparam int CD    = 2;
  localparam int EXP_N = (2 * DW + 2) * CD;

  typedef struct {
    logic       cpol, cpha, lsb;
    logic [1:0] cs;
    logic [7:0] tx;
    logic       loop;
    logic [7:0] sw;
    logic [7:0] exp_rx;
    logic [3:0] exp_cs;
    logic       poke;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [1:0] cs_sel = '0;
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic       miso;
  logic       sclk, mosi, busy, done;
  logic [3:0] cs_n;
  logic [7:0] rx_data;

  logic       start2 = 1'b0;
  logic [2:0] cs_sel2 = '0;
  logic       miso2 = 1'b1;
  logic       sclk2, mosi2, busy2, done2;
  logic [4:0] cs_n2;
  logic [7:0] rx2;

  int n_vec = 0, n_err = 0;
  logic cur_cpol = 0, cur_cpha = 0, cur_lsb = 0, cur_loop = 0;
  logic [7:0] cur_sw = '0;
  int lead_cnt = 0, trail_cnt = 0;
  logic sclk_prev = 1'b0, is_lead, eb;
  logic [7:0] erx;
  logic exp_bit_q[$];
  logic [7:0] exp_rx_q[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(4)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .cs_sel(cs_sel), .start(start), .tx_data(tx_data), .miso(miso),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done), .rx_data(rx_data)
  );

  spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(5)) dut2 (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .cs_sel(cs_sel2), .start(start2), .tx_data(tx_data), .miso(miso2),
    .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2), .busy(busy2), .done(done2), .rx_data(rx2)
  );

  // Slave shifts on the edge opposite to the master's sampling edge.
  function automatic logic slave_bit(input logic [7:0] w, input logic lsb, input logic cph,
                                     input int lc, input int tc);
    int idx = cph ? lc - 1 : tc;
    if (idx < 0) idx = 0;
    if (idx > DW - 1) idx = DW - 1;
    return lsb ? w[idx] : w[DW-1-idx];
  endfunction

  assign miso = cur_loop ? mosi : slave_bit(cur_sw, cur_lsb, cur_cpha, lead_cnt, trail_cnt);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (&cs_n) begin
      lead_cnt  = 0;
      trail_cnt = 0;
    end else if (sclk !== sclk_prev) begin
      is_lead = (sclk_prev == cur_cpol);
      if (is_lead) lead_cnt++;
      else         trail_cnt++;
      if (is_lead != cur_cpha) begin
        if (exp_bit_q.size() == 0) chk("mosi_extra_edge", 1, 0);
        else begin
          eb = exp_bit_q.pop_front();
          chk("mosi_bit", {31'd0, mosi}, {31'd0, eb});
        end
      end
    end
    sclk_prev = sclk;
    if (done === 1'b1) begin
      if (exp_rx_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        erx = exp_rx_q.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, erx});
      end
    end
  end

  function automatic vec_t mk(input logic [1:0] mode, input logic lsb, input logic [1:0] cs,
                              input logic [7:0] tx, input logic loop, input logic [7:0] sw,
                              input logic [7:0] rx, input logic [3:0] ecs, input logic poke);
    vec_t v;
    {v.cpol, v.cpha} = mode;
    v.lsb = lsb; v.cs = cs; v.tx = tx; v.loop = loop; v.sw = sw;
    v.exp_rx = rx; v.exp_cs = ecs; v.poke = poke;
    return v;
  endfunction

  task automatic launch(input vec_t v);
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; cs_sel = v.cs; tx_data = v.tx;
    cur_cpol = v.cpol; cur_cpha = v.cpha; cur_lsb = v.lsb; cur_loop = v.loop; cur_sw = v.sw;
    for (int i = 0; i < DW; i++) exp_bit_q.push_back(v.lsb ? v.tx[i] : v.tx[DW-1-i]);
    exp_rx_q.push_back(v.exp_rx);
    start = 1'b1;
  endtask

  task automatic track(input vec_t v, input bit b2b, input vec_t nv);
    int n = 0;
    bit cs_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_accept", {31'd0, busy}, 1);
    chk("cs_on_accept", {28'd0, cs_n}, {28'd0, v.exp_cs});
    chk("sclk_setup_idle", {31'd0, sclk}, {31'd0, v.cpol});
    chk("done_low_after_accept", {31'd0, done}, 0);
    while (done !== 1'b1 && n < 200) begin
      if (cs_n !== v.exp_cs) cs_ok = 1'b0;
      if (v.poke && n == 10) begin start = 1'b1; tx_data = ~v.tx; end
      if (v.poke && n == 11) start = 1'b0;
      if (n == EXP_N - 1) chk("sclk_hold_idle", {31'd0, sclk}, {31'd0, v.cpol});
      @(negedge clk);
      n++;
    end
    chk("cs_held_through_xfer", {31'd0, cs_ok}, 1);
    chk("done_latency", n, EXP_N);
    chk("cs_released_at_done", {28'd0, cs_n}, 32'hF);
    chk("busy_low_at_done", {31'd0, busy}, 0);
    if (b2b) launch(nv);
    else begin
      @(negedge clk);
      chk("done_single_cycle", {31'd0, done}, 0);
    end
  endtask

  initial begin
    int n;
    bit seen;
    vec_t va, vb, vr, vn;

    tbl[0] = mk(MODE0, 0, 2'd0, 8'hA5, 1, 8'h00, 8'hA5, 4'b1110, 0);
    tbl[1] = mk(MODE1, 0, 2'd0, 8'h3C, 0, 8'hC3, 8'hC3, 4'b1110, 0);
    tbl[2] = mk(MODE2, 0, 2'd0, 8'h3C, 0, 8'hC3, 8'hC3, 4'b1110, 0);
    tbl[3] = mk(MODE3, 0, 2'd0, 8'h3C, 0, 8'hC3, 8'hC3, 4'b1110, 0);
    tbl[4] = mk(MODE0, 1, 2'd0, 8'h01, 1, 8'h00, 8'h01, 4'b1110, 0);
    tbl[5] = mk(MODE0, 0, 2'd2, 8'h5A, 0, 8'h96, 8'h96, 4'b1011, 0);
    tbl[6] = mk(MODE3, 1, 2'd3, 8'h81, 0, 8'h4D, 8'h4D, 4'b0111, 1);

    repeat (3) @(negedge clk);
    chk("rst_sclk", {31'd0, sclk}, 0);
    chk("rst_mosi", {31'd0, mosi}, 0);
    chk("rst_cs_n", {28'd0, cs_n}, 32'hF);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rx", {24'd0, rx_data}, 0);
    chk("rst_cs_n2", {27'd0, cs_n2}, 32'h1F);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Out-of-range select on the 5-slave instance, then the highest legal one.
    cs_sel2 = 3'd5; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("cs5_rejected_busy", {31'd0, busy2}, 0);
    chk("cs5_rejected_cs", {27'd0, cs_n2}, 32'h1F);
    repeat (3) @(negedge clk);
    chk("cs5_still_idle", {29'd0, busy2, sclk2, mosi2}, 0);
    cs_sel2 = 3'd4; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("cs4_accepted_busy", {31'd0, busy2}, 1);
    chk("cs4_accepted_cs", {27'd0, cs_n2}, 32'h0F);
    n = 0;
    while (done2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("cs4_done_latency", n, EXP_N);
    chk("cs4_rx_all_ones", {24'd0, rx2}, 32'hFF);

    foreach (tbl[i]) begin
      cpol = tbl[i].cpol;
      repeat (2) @(negedge clk);
      launch(tbl[i]);
      track(tbl[i], 1'b0, tbl[i]);
    end
    @(negedge clk);
    chk("sclk_idle_after", {31'd0, sclk}, {31'd0, cpol});

    // Back-to-back: second start presented in the done cycle of a disturbed transfer.
    va = mk(MODE1, 0, 2'd1, 8'h96, 1, 8'h00, 8'h96, 4'b1101, 1);
    vb = mk(MODE1, 0, 2'd1, 8'h33, 0, 8'h5C, 8'h5C, 4'b1101, 0);
    cpol = va.cpol;
    repeat (2) @(negedge clk);
    launch(va);
    track(va, 1'b1, vb);
    track(vb, 1'b0, vb);

    // Reset around bit 4 of a mode-2 transfer, then a clean transfer.
    vr = mk(MODE2, 0, 2'd0, 8'hF0, 1, 8'h00, 8'hF0, 4'b1110, 0);
    vn = mk(MODE2, 0, 2'd0, 8'h6B, 1, 8'h00, 8'h6B, 4'b1110, 0);
    cpol = vr.cpol;
    repeat (2) @(negedge clk);
    launch(vr);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_bit_q.delete();
    exp_rx_q.delete();
    chk("abort_cs_n", {28'd0, cs_n}, 32'hF);
    chk("abort_sclk", {31'd0, sclk}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_rx", {24'd0, rx_data}, 0);
    seen = 1'b0;
    repeat (40) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", {31'd0, seen}, 0);
    launch(vn);
    track(vn, 1'b0, vn);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_bit_q.size() + exp_rx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
